// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous video RAM between the
// VGA read path (priority) and an in-order, FIFO-buffered CPU port.
// Ports:
//   clk, reset_n                          clock, async active-low reset
//   vga_req, vga_address -> vga_data      VGA fetch path (2-cycle latency)
//   cpu_we/re/addr/wdata, cpu_ready       CPU request accept side
//   cpu_rdata, cpu_rvalid                 CPU read return (1-cycle pulse)
//   mem_addr/we/wdata, mem_rdata          RAM port (read data 1 cycle late)
module vram_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_address,
    output logic [DATA_W-1:0] vga_data,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {G_IDLE, G_VGA, G_CPU} grant_e;
    typedef enum logic [1:0] {T_OTHER, T_VGA, T_CPURD} tag_e;

    logic              fifo_we_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SC_W-1:0]  starve_q, starve_d;
    tag_e             tag_q, tag_d;

    logic [DATA_W-1:0] vga_data_q, cpu_rdata_q;
    logic              cpu_rvalid_q;

    logic              empty, full, push, pop, force_cpu;
    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    grant_e            grant;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign cpu_ready = !full;
    // A push while full is dropped even if this cycle also pops.
    assign push      = (cpu_we | cpu_re) & !full;
    assign force_cpu = (starve_q == SC_W'(STARVE_MAX)) && !empty;

    assign head_we   = fifo_we_q[rd_ptr_q];
    assign head_addr = fifo_addr_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        grant = G_IDLE;
        if (force_cpu)   grant = G_CPU;
        else if (vga_req) grant = G_VGA;
        else if (!empty)  grant = G_CPU;
    end

    assign pop = (grant == G_CPU);

    // RAM port is combinational from the grant; held at zero during reset
    // so the outputs show their reset values immediately.
    always_comb begin
        mem_addr  = vga_address;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (pop) begin
            mem_addr  = head_addr;
            mem_we    = head_we;
            mem_wdata = head_data;
        end
        if (!reset_n) begin
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (empty || pop)
            starve_d = '0;
        else if (starve_q != SC_W'(STARVE_MAX))
            starve_d = starve_q + 1'b1;
    end

    // Tag tells next cycle what the RAM read data belongs to.
    always_comb begin
        tag_d = T_OTHER;
        if (grant == G_VGA)      tag_d = T_VGA;
        else if (pop && !head_we) tag_d = T_CPURD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_we_q[i]   <= 1'b0;
                fifo_addr_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
        end else if (push) begin
            fifo_we_q[wr_ptr_q]   <= cpu_we;
            fifo_addr_q[wr_ptr_q] <= cpu_addr;
            fifo_data_q[wr_ptr_q] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            tag_q    <= T_OTHER;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            tag_q    <= tag_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vga_data_q   <= '0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q <= 1'b0;
            if (tag_q == T_VGA)
                vga_data_q <= mem_rdata;
            if (tag_q == T_CPURD) begin
                cpu_rdata_q  <= mem_rdata;
                cpu_rvalid_q <= 1'b1;
            end
        end
    end

    assign vga_data   = vga_data_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port synchronous video RAM between the VGA pixel path and a CPU port. The VGA read port has priority. CPU reads and writes are buffered in a small in-order request FIFO and drain on cycles the VGA path does not need. A starvation guard forces a CPU slot after a bounded wait. The block sits directly upstream of the VGA top-level: it consumes its 15-bit `vga_address` and returns 16-bit `vga_data`.

## Interface
- `ADDR_W`, default 15: RAM word-address width.
- `DATA_W`, default 16: RAM word width.
- `FIFO_DEPTH`, default 4: CPU request FIFO entries; must be a power of two, at least 2.
- `STARVE_MAX`, default 64: consecutive denied cycles before a CPU slot is forced.

Ports:
- `clk` in 1: the single clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `vga_req` in 1: VGA path wants a read this cycle; tie high for continuous fetch.
- `vga_address` in ADDR_W: VGA read address.
- `vga_data` out DATA_W: registered VGA read data.
- `cpu_we` in 1: CPU write request.
- `cpu_re` in 1: CPU read request.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_ready` out 1: FIFO not full; a request is accepted this cycle.
- `cpu_rdata` out DATA_W: CPU read data.
- `cpu_rvalid` out 1: one-cycle pulse; `cpu_rdata` is valid.
- `mem_addr` out ADDR_W: RAM address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data, valid the cycle after the address is presented.

## Operation
- **Accept.** A CPU request is accepted when `(cpu_we|cpu_re) && cpu_ready`.
  - If both strobes are high, it is a write; the read is dropped.
  - Each FIFO entry stores {we, addr, wdata}.
- **cpu_ready.** Equals `count != FIFO_DEPTH`, decoded from the registered count.
  - A push while full is ignored, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full leave the count unchanged.
- **Grant.** One grant per cycle, combinational from the current state:
  - FORCE: `starve_cnt == STARVE_MAX` and FIFO non-empty → CPU head.
  - else VGA: `vga_req` → `mem_addr = vga_address`, `mem_we = 0`.
  - else CPU: FIFO non-empty → pop head; `mem_addr` = head.addr, `mem_we` = head.we, `mem_wdata` = head.wdata.
  - else IDLE: `mem_we = 0`, `mem_addr` = `vga_address`.
- **Starvation counter.**
  - Increments, saturating at STARVE_MAX, on each cycle the FIFO is non-empty and the CPU is not granted.
  - Clears on any CPU grant and whenever the FIFO is empty.
- **Read returns.**
  - A registered tag records the previous cycle's grant type: VGA, CPU read, or other.
  - Tag VGA: `vga_data <= mem_rdata`.
  - Tag CPU read: `cpu_rdata <= mem_rdata` and `cpu_rvalid <= 1`.
  - Otherwise `vga_data` and `cpu_rdata` hold, and `cpu_rvalid <= 0`.
- **Ordering.** The FIFO is strictly in order, so a CPU read after a CPU write to the same address returns the new data.
- **Reset mid-operation.** Empties the FIFO and discards any in-flight read; no `cpu_rvalid` is produced for it.

## Timing
- Reset values:
  - `vga_data` = 0, `cpu_rdata` = 0, `cpu_rvalid` = 0.
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `cpu_ready` = 1; FIFO count = 0; `starve_cnt` = 0; tag = other.
- VGA latency: address granted in cycle N → `vga_data` updates at the edge ending cycle N+1, i.e. visible in N+2 (2 cycles).
- CPU read latency, with an empty FIFO and `vga_req` low:
  - Accepted at edge E.
  - Granted in the cycle after E.
  - `cpu_rvalid` is high for exactly one cycle, two cycles after E.
- CPU write: RAM is written at the end of its grant cycle; the earliest grant is the cycle after acceptance.
- On a FORCE cycle, `vga_data` is not updated for that slot. The VGA path must tolerate one missed fetch per STARVE_MAX+1 cycles under saturation.
- Pointers wrap modulo FIFO_DEPTH; the count has width log2(FIFO_DEPTH)+1.

## Test plan
- **Reset.** Assert `reset_n=0` mid-traffic → all outputs at their reset values immediately (asynchronously), `cpu_ready=1`. After release, no `cpu_rvalid` appears for a read that was pending.
- **VGA stream.** `vga_req=1`, `vga_address` = 0,1,2,… with RAM model data = addr^16'hA5A5 → `vga_data` tracks with 2-cycle latency, `mem_we` never asserted.
- **CPU write then read, vga_req=0.**
  - Write 0x0123←0xBEEF, then read 0x0123.
  - Required: `mem_we` for exactly one cycle.
  - Required: `cpu_rvalid` pulses once with `cpu_rdata=0xBEEF`.
- **FIFO full.**
  - `vga_req=1`, `STARVE_MAX` large; push 5 writes back-to-back.
  - Required: `cpu_ready` drops after 4 accepted and the 5th is not stored.
  - Then drop `vga_req` → 4 RAM writes in order, `cpu_ready` returns to 1.
- **Starvation.**
  - `vga_req` held high with `STARVE_MAX=8`; queue one read of 0x0010 (RAM=0x1234).
  - Required: exactly 8 VGA grants after the push, then a forced CPU grant.
  - Required: `cpu_rvalid` with 0x1234; `vga_data` holds across the forced slot.
- **Simultaneous strobes.** `cpu_we=cpu_re=1` at 0x0001, `wdata=0x5555` → one write entry; RAM[1]=0x5555; no `cpu_rvalid`.
